uart_rx: RTL and testbench

Asynchronous serial receiver, 8N1, LSB first. It is the receive-side counterpart of the existing transmitter: it takes the FTDI `ftdi_rx` line and delivers bytes to downstream logic such as a command parser or a loopback into the transmitter. It oversamples the line with the system clock, validates start and stop bits, and presents each byte through a valid/ready holding register with overrun and framing-error flags.

---
 rtl/uart_rx.sv | 152 +++++++++++++++
 tb/tb_uart_rx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 LSB-first serial receiver with a valid/ready holding register, framing-error and overrun pulses.
// Define UART_RX_MAJORITY_EN to make every bit decision a 2-of-3 vote over the last three rx_s samples.
module uart_rx #(
    parameter int CLKS_PER_BIT = 1250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic [1:0] dbg_state
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Handshake: a byte transfers on any posedge where out_valid && out_ready;
    // out_valid never depends combinationally on out_ready.
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [1:0]       sync_q;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             load;
    logic             rx_s;
    logic             line_bit;

    assign rx_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], rx_s};
        end
    end

    assign line_bit = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign line_bit = rx_s;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        load        = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    idx_d = '0;
                    state_d = line_bit ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = line_bit;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                cnt_d = cnt_q + 1'b1;
                // Leaving mid-stop-bit lets an immediately following start edge be caught.
                if (cnt_q == CNT_LAST) begin
                    cnt_d       = '0;
                    state_d     = S_IDLE;
                    load        = line_bit;
                    frame_err_d = ~line_bit;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q & ~out_ready;
        overrun_d   = 1'b0;
        if (load) begin
            if (out_valid_q && !out_ready) begin
                overrun_d = 1'b1;
            end else begin
                out_data_d  = shift_q;
                out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            sync_q      <= 2'b11;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            sync_q      <= {sync_q[0], rx};
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames are driven bit by bit, expected events are queued by a
// frame-level model and a negedge monitor pops and compares them, including arrival cycle.
module tb_uart_rx;

    localparam int C = 16;
    localparam int H = C / 2;
    localparam logic [1:0] EV_ACC = 2'd0;
    localparam logic [1:0] EV_FE  = 2'd1;
    localparam logic [1:0] EV_OVR = 2'd2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_valid;
    logic       frame_err;
    logic       overrun;
    logic [1:0] dbg_state;

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .dbg_state (dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;

    logic [19:0] cyc = '0;
    always @(posedge clk) cyc <= cyc + 20'd1;

    // scoreboard: {type, byte, cycle}
    logic [29:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    logic       model_full = 1'b0;
    logic [7:0] model_byte = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic sb_pop(input logic [29:0] act);
        logic [29:0] req;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got type=%0d data=%0h cycle=%0d, expected none",
                     act[29:28], act[27:20], act[19:0]);
        end else begin
            req = exp_q.pop_front();
            if (act !== req) begin
                errors++;
                $display("FAIL event: got type=%0d data=%0h cycle=%0d, expected type=%0d data=%0h cycle=%0d",
                         act[29:28], act[27:20], act[19:0], req[29:28], req[27:20], req[19:0]);
            end
        end
    endtask

    // monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) sb_pop({EV_FE, 8'h00, cyc});
            if (overrun) sb_pop({EV_OVR, out_data, cyc});
            if (out_valid && out_ready) sb_pop({EV_ACC, out_data, cyc});
        end
    end

    // Frame-level model: the stop decision lands H+9C+3 counts after the cycle the start bit is driven.
    task automatic expect_frame(input logic [7:0] b, input bit stop_ok, input logic [19:0] s);
        logic [19:0] t;
        t = s + 20'(H + 9 * C + 3);
        if (!stop_ok) exp_q.push_back({EV_FE, 8'h00, t});
        else if (out_ready) exp_q.push_back({EV_ACC, b, t});
        else if (model_full) exp_q.push_back({EV_OVR, model_byte, t});
        else begin
            model_full = 1'b1;
            model_byte = b;
        end
    endtask

    // drivers
    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop, input bit spike, input int rst_at);
        logic [9:0] bits;
        logic       lvl;
        bits = {stop, b, 1'b0};
        if (rst_at < 0) expect_frame(b, stop, cyc);
        for (int t = 0; t < 10 * C; t++) begin
            lvl = bits[t / C];
            if (spike && (t % C) == H) lvl = ~lvl;
            rx = lvl;
            if (t == rst_at) rst_n = 1'b0;
            @(posedge clk);
            #1;
            if (t == rst_at) begin
                rst_n = 1'b1;
                model_full = 1'b0;
                check("rst_out_valid", out_valid, 0);
                check("rst_out_data", out_data, 0);
                check("rst_frame_err", frame_err, 0);
                check("rst_overrun", overrun, 0);
                rx = 1'b1;
                return;
            end
        end
    endtask

    task automatic raise_ready();
        if (model_full) exp_q.push_back({EV_ACC, model_byte, cyc});
        model_full = 1'b0;
        out_ready = 1'b1;
    endtask

    // stimulus
    initial begin
        logic [7:0] b;
        bit         stop;
        int         gap;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_overrun", overrun, 0);
        rst_n = 1'b1;
        idle(5);

        send_frame(8'h41, 1'b1, 1'b0, -1);
        idle(10);

        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        idle(30);
        send_frame(8'hA5, 1'b1, 1'b0, -1);
        idle(10);

        send_frame(8'h3C, 1'b0, 1'b0, -1);
        idle(20);

        out_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0, -1);
        send_frame(8'h22, 1'b1, 1'b0, -1);
        idle(10);
        check("held_data", out_data, 8'h11);
        check("held_valid", out_valid, 1);
        raise_ready();
        @(posedge clk);
        #1;
        check("valid_after_accept", out_valid, 0);
        idle(5);

        send_frame(8'h00, 1'b1, 1'b0, -1);
        send_frame(8'hFF, 1'b1, 1'b0, -1);
        send_frame(8'h55, 1'b1, 1'b0, -1);
        idle(10);
`ifdef UART_RX_MAJORITY_EN
        send_frame(8'h00, 1'b1, 1'b1, -1);
        send_frame(8'hFF, 1'b1, 1'b1, -1);
        send_frame(8'h55, 1'b1, 1'b1, -1);
        idle(10);
`endif

        send_frame(8'h99, 1'b1, 1'b0, 4 * C + 4);
        idle(20);
        send_frame(8'h99, 1'b1, 1'b0, -1);
        idle(10);

        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 7) != 0);
            gap = stop ? $urandom_range(0, 20) : 20 + $urandom_range(0, 10);
            send_frame(b, stop, 1'b0, -1);
            idle(gap);
        end

        idle(50);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
